// File: rtl/column_sweeper.sv
// One drum column: holds current/previous displacement per node and sweeps rows through an external node solver.
// Optional MID_TAP_EN adds a mid-column sample tap (mid_sample/mid_valid).
module column_sweeper #(
  parameter int ROWS = 32,
  localparam int AW = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               init_we,
  input  logic [AW-1:0]      init_row,
  input  logic signed [17:0] init_u,
  input  logic [AW-1:0]      rd_row,
  output logic signed [17:0] rd_data,
  input  logic signed [17:0] u_left,
  input  logic signed [17:0] u_right,
  output logic signed [17:0] u_center,
  output logic signed [17:0] s_up,
  output logic signed [17:0] s_down,
  output logic signed [17:0] s_center,
  output logic signed [17:0] s_prev,
  output logic signed [17:0] s_left,
  output logic signed [17:0] s_right,
`ifdef MID_TAP_EN
  output logic signed [17:0] mid_sample,
  output logic               mid_valid,
`endif
  input  logic signed [17:0] s_next
);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, RUN, FIN} state_t;

  state_t state;
  logic [AW-1:0] row;
  logic signed [17:0] center_r, prev_r, down_r;

  logic signed [17:0] curr_mem [ROWS];
  logic signed [17:0] prev_mem [ROWS];
  logic signed [17:0] curr_q, prev_q;

  logic [AW-1:0] rd_addr;
  logic curr_we, prev_we;
  logic [AW-1:0] wr_addr;
  logic signed [17:0] curr_wd, prev_wd;

  logic is_run, last_row;

  assign is_run   = (state == RUN);
  assign last_row = (row == AW'(ROWS - 1));

  // Read port runs two rows ahead of the row being solved so s_up is ready in time.
  always_comb begin
    rd_addr = rd_row;
    case (state)
      LOAD0: rd_addr = '0;
      LOAD1: rd_addr = AW'(1);
      RUN: begin
        if (int'(row) + 2 < ROWS) rd_addr = row + AW'(2);
        else rd_addr = '0;
      end
      default: rd_addr = rd_row;
    endcase
  end

  always_comb begin
    curr_we = 1'b0;
    prev_we = 1'b0;
    wr_addr = init_row;
    curr_wd = init_u;
    prev_wd = init_u;
    if (state == IDLE && init_we) begin
      curr_we = 1'b1;
      prev_we = 1'b1;
    end else if (is_run) begin
      curr_we = 1'b1;
      prev_we = 1'b1;
      wr_addr = row;
      curr_wd = s_next;
      prev_wd = center_r;
    end
  end

  // Storage arrays are deliberately outside reset so a reset never wipes the drum state.
  always_ff @(posedge clk) begin
    if (curr_we) curr_mem[wr_addr] <= curr_wd;
    if (prev_we) prev_mem[wr_addr] <= prev_wd;
    curr_q <= curr_mem[rd_addr];
    prev_q <= prev_mem[rd_addr];
  end

  assign rd_data = curr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      row      <= '0;
      center_r <= '0;
      prev_r   <= '0;
      down_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD0;
            busy  <= 1'b1;
          end
        end
        LOAD0: state <= LOAD1;
        LOAD1: begin
          center_r <= curr_q;
          prev_r   <= prev_q;
          down_r   <= '0;
          row      <= '0;
          state    <= RUN;
        end
        RUN: begin
          // down_r keeps the pre-sweep centre, never the freshly written s_next.
          down_r   <= center_r;
          center_r <= curr_q;
          prev_r   <= prev_q;
          if (last_row) begin
            state <= FIN;
            done  <= 1'b1;
            row   <= '0;
          end else begin
            row <= row + AW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_center = is_run ? center_r : '0;
  assign s_prev   = is_run ? prev_r : '0;
  assign s_down   = is_run ? down_r : '0;
  assign s_up     = (is_run && !last_row) ? curr_q : '0;
  assign s_left   = is_run ? u_left : '0;
  assign s_right  = is_run ? u_right : '0;
  assign u_center = s_center;

`ifdef MID_TAP_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      mid_sample <= '0;
      mid_valid  <= 1'b0;
    end else begin
      mid_valid <= 1'b0;
      if (is_run && row == AW'(ROWS / 2)) begin
        mid_sample <= s_next;
        mid_valid  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_column_sweeper.sv
// Directed self-checking bench for column_sweeper (ROWS = 4) with a stub solver s_next = s_up + s_down or s_prev.
// Define MID_TAP_EN to also check the mid-column tap.
module tb_column_sweeper;

  localparam int ROWS = 4;

  logic clk = 1'b0;
  logic rst, start, busy, done, init_we;
  logic [1:0] init_row, rd_row;
  logic signed [17:0] init_u, rd_data, u_left, u_right, u_center;
  logic signed [17:0] s_up, s_down, s_center, s_prev, s_left, s_right, s_next;
`ifdef MID_TAP_EN
  logic signed [17:0] mid_sample;
  logic mid_valid;
`endif
  logic use_prev;

  int n_cmp = 0;
  int n_fail = 0;

  logic signed [17:0] cap_up [4];
  logic signed [17:0] cap_down [4];
  logic signed [17:0] cap_center [4];
  logic signed [17:0] cap_prev [4];
  int mid_pulses, mid_at;
  logic signed [17:0] mid_val;

  column_sweeper #(.ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .init_we(init_we), .init_row(init_row), .init_u(init_u),
    .rd_row(rd_row), .rd_data(rd_data),
    .u_left(u_left), .u_right(u_right), .u_center(u_center),
    .s_up(s_up), .s_down(s_down), .s_center(s_center), .s_prev(s_prev),
    .s_left(s_left), .s_right(s_right),
`ifdef MID_TAP_EN
    .mid_sample(mid_sample), .mid_valid(mid_valid),
`endif
    .s_next(s_next)
  );

  always #5 clk = ~clk;

  assign s_next = use_prev ? s_prev : s_up + s_down;

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_node(input int r, input int v);
    init_we  = 1'b1;
    init_row = 2'(r);
    init_u   = 18'(v);
    tick();
    init_we  = 1'b0;
  endtask

  task automatic init_column(input int a, input int b, input int c, input int d);
    write_node(0, a);
    write_node(1, b);
    write_node(2, c);
    write_node(3, d);
  endtask

  task automatic read_check(input string tag, input int a, input int b, input int c, input int d);
    int exp_vals [4];
    exp_vals[0] = a; exp_vals[1] = b; exp_vals[2] = c; exp_vals[3] = d;
    for (int r = 0; r < 4; r++) begin
      rd_row = 2'(r);
      tick();
      check_output($sformatf("%s_row%0d", tag, r), rd_data, exp_vals[r]);
    end
  endtask

  task automatic apply_stimulus(input bit extra_start, input bit poke_init,
                                output int lat, output int pulses);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    pulses = 0;
    mid_pulses = 0;
    mid_at = -1;
    mid_val = '0;
    for (int k = 1; k <= 12; k++) begin
      if (extra_start && k == 2) start = 1'b1;
      if (poke_init && k == 3) begin
        init_we = 1'b1; init_row = 2'd0; init_u = 18'sd99;
      end
      tick();
      start = 1'b0;
      init_we = 1'b0;
      if (done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k >= 2 && k <= 5) begin
        cap_up[k-2]     = s_up;
        cap_down[k-2]   = s_down;
        cap_center[k-2] = s_center;
        cap_prev[k-2]   = s_prev;
      end
`ifdef MID_TAP_EN
      if (mid_valid) begin
        mid_pulses++;
        mid_at = k;
        mid_val = mid_sample;
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, pulses, quiet_done;
    rst = 1'b0; start = 1'b0; init_we = 1'b0; init_row = '0; init_u = '0;
    rd_row = '0; u_left = '0; u_right = '0; use_prev = 1'b0;

    tick();
    tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_u_center", u_center, 0);
    check_output("rst_s_up", s_up, 0);
    check_output("rst_s_down", s_down, 0);
    check_output("rst_s_prev", s_prev, 0);
`ifdef MID_TAP_EN
    check_output("rst_mid_sample", mid_sample, 0);
    check_output("rst_mid_valid", mid_valid, 0);
`endif
    rst = 1'b1;
    tick();

    $display("[TB] basic sweep");
    init_column(1, 2, 3, 4);
    apply_stimulus(1'b0, 1'b0, lat, pulses);
    check_output("basic_latency", lat, 6);
    check_output("basic_done_pulses", pulses, 1);
    check_output("row0_s_down", cap_down[0], 0);
    check_output("row0_s_up", cap_up[0], 2);
    check_output("row1_s_center", cap_center[1], 2);
    check_output("row1_s_down", cap_down[1], 1);
    check_output("row1_s_prev", cap_prev[1], 2);
    check_output("row2_s_center", cap_center[2], 3);
    check_output("row3_s_up", cap_up[3], 0);
    check_output("row3_s_down", cap_down[3], 3);
    check_output("idle_busy", busy, 0);
    check_output("idle_s_center", s_center, 0);
`ifdef MID_TAP_EN
    check_output("mid_pulses", mid_pulses, 1);
    check_output("mid_at", mid_at, 5);
    check_output("mid_val", mid_val, 6);
    check_output("mid_hold", mid_sample, 6);
`endif
    read_check("basic", 2, 4, 6, 3);

    $display("[TB] second sweep");
    apply_stimulus(1'b0, 1'b0, lat, pulses);
    check_output("second_latency", lat, 6);
    read_check("second", 4, 8, 7, 6);

    $display("[TB] third sweep exposes prev");
    use_prev = 1'b1;
    apply_stimulus(1'b0, 1'b0, lat, pulses);
    use_prev = 1'b0;
    read_check("prev", 2, 4, 6, 3);

    $display("[TB] start and init_we while busy");
    init_column(1, 2, 3, 4);
    apply_stimulus(1'b1, 1'b1, lat, pulses);
    check_output("busy_start_pulses", pulses, 1);
    check_output("busy_start_latency", lat, 6);
    read_check("busy_start", 2, 4, 6, 3);

    $display("[TB] reset mid-sweep");
    init_column(1, 2, 3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    rst = 1'b1;
    quiet_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) quiet_done++;
    end
    check_output("midrst_no_done", quiet_done, 0);
    read_check("midrst", 2, 4, 3, 4);
    apply_stimulus(1'b0, 1'b0, lat, pulses);
    check_output("after_rst_latency", lat, 6);
    check_output("after_rst_pulses", pulses, 1);
    read_check("after_rst", 4, 5, 8, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
